// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad encoder.
package keypad_pkg;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] KEY_NONE = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  function automatic int frame_len(input int cols, input int scan_div);
    return cols * scan_div;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner: synchronizes the row inputs, walks the column drive and
// reports the lowest key code seen in each full scan frame.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [COLS-1:0]   col_out,
  input  logic [ROWS-1:0]   row_in,
  output logic              frame_done,
  output logic [CODE_W-1:0] frame_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROWS-1:0]   sync1_q, sync1_d;
  logic [ROWS-1:0]   sync2_q, sync2_d;
  logic [CODE_W-1:0] best_q, best_d;
  logic              last_dwell;
  logic [CODE_W-1:0] col_code;
  logic [CODE_W-1:0] merged;

  always_comb begin
    sync1_d    = row_in;
    sync2_d    = sync1_q;
    last_dwell = (div_q == DIV_LAST);
    div_d      = last_dwell ? '0 : div_q + 1'b1;
    col_d      = col_q;
    if (last_dwell) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    // Rows are walked high to low so the lowest row, and thus lowest code, wins.
    col_code = KEY_NONE;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (sync2_q[r]) begin
        col_code = CODE_W'(r * COLS + int'(col_q) + 1);
      end
    end

    merged = best_q;
    if (last_dwell && (col_code != KEY_NONE) &&
        ((best_q == KEY_NONE) || (col_code < best_q))) begin
      merged = col_code;
    end

    frame_done = last_dwell && (col_q == COL_LAST);
    frame_code = merged;
    best_d     = frame_done ? KEY_NONE : merged;

    col_out        = '0;
    col_out[col_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      col_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      best_q  <= KEY_NONE;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      best_q  <= best_d;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Matrix keypad front-end: debounced press/release FSM driving KEY_CODE and
// KEY_EVENT. Defining KEYPAD_REPEAT_EN adds auto-repeat pulses while held.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic              CK,
  input  logic              RST_N,
  output logic [COLS-1:0]   COL_OUT,
  input  logic [ROWS-1:0]   ROW_IN,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_EVENT
);

  if ((ROWS * COLS > 255) || (SCAN_DIV < 3) || (DEBOUNCE < 1) ||
      (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_param_check
    $error("keypad_encoder: illegal parameter set");
  end

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE);
  localparam bit SINGLE = (DEBOUNCE == 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              event_q, event_d;
  logic              frame_done;
  logic [CODE_W-1:0] frame_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             armed_q, armed_d;
`endif

  keypad_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (CK),
    .rst_n      (RST_N),
    .col_out    (COL_OUT),
    .row_in     (ROW_IN),
    .frame_done (frame_done),
    .frame_code (frame_code)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    event_d = event_q;
    cnt_inc = cnt_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    armed_d = armed_q;
    rep_inc = rep_q + 1'b1;
    // A repeat drop lasts one clock; a frame is always longer than that.
    if ((state_q == ST_PRESSED) && !event_q) begin
      event_d = 1'b1;
    end
`endif

    if (frame_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_code != KEY_NONE) begin
            cand_d  = frame_code;
            cnt_d   = CNT_ONE;
            state_d = ST_DEBOUNCE;
            if (SINGLE) begin
              state_d = ST_PRESSED;
              code_d  = frame_code;
              event_d = 1'b1;
              cnt_d   = '0;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_code == KEY_NONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_TARGET) begin
              state_d = ST_PRESSED;
              code_d  = cand_q;
              event_d = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end
        end
        ST_PRESSED: begin
          // Any other result, including an extra key, starts the release count.
          if (frame_code != code_q) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_ONE;
            if (SINGLE) begin
              state_d = ST_IDLE;
              code_d  = KEY_NONE;
              event_d = 1'b0;
              cnt_d   = '0;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_d = rep_inc;
            if (rep_inc == (armed_q ? REP_NEXT : REP_FIRST)) begin
              event_d = 1'b0;
              rep_d   = '0;
              armed_d = 1'b1;
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (frame_code == code_q) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_TARGET) begin
              state_d = ST_IDLE;
              code_d  = KEY_NONE;
              event_d = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    if ((state_q != ST_PRESSED) || (state_d != ST_PRESSED)) begin
      rep_d   = '0;
      armed_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      code_q  <= KEY_NONE;
      event_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
      armed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      event_q <= event_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
      armed_q <= armed_d;
`endif
    end
  end

  assign KEY_CODE  = code_q;
  assign KEY_EVENT = event_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random key
// patterns, compared clock by clock against a frame-level reference model.
module tb_keypad_encoder;
  import keypad_pkg::*;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE     = 3;
  localparam int REPEAT_DELAY = 8;
  localparam int REPEAT_RATE  = 4;
  localparam int FRAME_LEN    = frame_len(COLS, SCAN_DIV);
  localparam int NKEYS        = ROWS * COLS;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_DROPS = 3;
`else
  localparam int REP_DROPS = 0;
`endif

  logic             CK = 1'b0;
  logic             RST_N;
  logic [COLS-1:0]  COL_OUT;
  logic [ROWS-1:0]  ROW_IN;
  logic [7:0]       KEY_CODE;
  logic             KEY_EVENT;
  logic [NKEYS-1:0] key_mask = '0;

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int low_cnt  = 0;
  int held, run_code, run_len, rel_cnt;
  bit drop;
`ifdef KEYPAD_REPEAT_EN
  int held_frames;
  bit armed;
`endif

  always #5 CK = ~CK;

  // Switch matrix: a row reads high when a closed key sits in the driven column.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      ROW_IN[r] = |(key_mask[r*COLS +: COLS] & COL_OUT);
    end
  end

  keypad_encoder #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .CK        (CK),
    .RST_N     (RST_N),
    .COL_OUT   (COL_OUT),
    .ROW_IN    (ROW_IN),
    .KEY_CODE  (KEY_CODE),
    .KEY_EVENT (KEY_EVENT)
  );

  function automatic logic [NKEYS-1:0] key_at(input int r, input int c);
    logic [NKEYS-1:0] m;
    m = '0;
    m[r*COLS + c] = 1'b1;
    return m;
  endfunction

  // Bit index r*COLS+c maps to code index+1, so the first set bit is the lowest code.
  function automatic int lowest_code(input logic [NKEYS-1:0] m);
    for (int i = 0; i < NKEYS; i++) begin
      if (m[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_clear();
    held     = 0;
    run_code = 0;
    run_len  = 0;
    rel_cnt  = 0;
    drop     = 1'b0;
    k        = 0;
`ifdef KEYPAD_REPEAT_EN
    held_frames = 0;
    armed       = 1'b0;
`endif
  endtask

  // Reference: a press is accepted after DEBOUNCE identical nonzero frames in a
  // row; it is dropped after DEBOUNCE consecutive frames that differ from it.
  task automatic model_frame();
    int res;
    res = lowest_code(key_mask);
    if (held == 0) begin
      if (res != 0) begin
        if (res == run_code) run_len++;
        else begin
          run_code = res;
          run_len  = 1;
        end
        if (run_len >= DEBOUNCE) begin
          held     = res;
          run_code = 0;
          run_len  = 0;
          rel_cnt  = 0;
`ifdef KEYPAD_REPEAT_EN
          held_frames = 0;
          armed       = 1'b0;
`endif
        end
      end else begin
        run_code = 0;
        run_len  = 0;
      end
    end else if (res == held) begin
      if (rel_cnt > 0) rel_cnt = 0;
`ifdef KEYPAD_REPEAT_EN
      else begin
        held_frames++;
        if (held_frames == (armed ? REPEAT_RATE : REPEAT_DELAY)) begin
          drop        = 1'b1;
          held_frames = 0;
          armed       = 1'b1;
        end
      end
`endif
    end else begin
      rel_cnt++;
`ifdef KEYPAD_REPEAT_EN
      held_frames = 0;
      armed       = 1'b0;
`endif
      if (rel_cnt >= DEBOUNCE) begin
        held     = 0;
        rel_cnt  = 0;
        run_code = 0;
        run_len  = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    int exp_col;
    @(posedge CK);
    #1;
    k++;
    drop = 1'b0;
    if (k % FRAME_LEN == 0) model_frame();
    exp_col = 1 << ((k / SCAN_DIV) % COLS);
    checkOutput("col_out", 32'(COL_OUT), exp_col);
    checkOutput("key_code", 32'(KEY_CODE), held);
    checkOutput("key_event", 32'(KEY_EVENT), 32'((held != 0) && !drop));
    if ((KEY_CODE != 8'd0) && !KEY_EVENT) low_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [NKEYS-1:0] m, input int frames);
    key_mask = m;
    ticks(frames * FRAME_LEN);
  endtask

  task automatic to_boundary();
    while (k % FRAME_LEN != 0) tick();
  endtask

  task automatic do_reset(input int cycles);
    RST_N = 1'b0;
    #1;
    checkOutput("rst_code", 32'(KEY_CODE), 0);
    checkOutput("rst_event", 32'(KEY_EVENT), 0);
    checkOutput("rst_col", 32'(COL_OUT), 1);
    repeat (cycles) @(posedge CK);
    @(negedge CK);
    RST_N = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [NKEYS-1:0] rnd_mask;
    rnd_mask = '0;
    RST_N = 1'b1;
    #2;
    do_reset(3);

    $display("[TB] idle scan after reset");
    ticks(200);
    to_boundary();

    $display("[TB] clean press of r0c1");
    key_mask = key_at(0, 1);
    ticks(3 * FRAME_LEN - 1);
    checkOutput("press_early", 32'(KEY_EVENT), 0);
    tick();
    checkOutput("press_event", 32'(KEY_EVENT), 1);
    checkOutput("press_code", 32'(KEY_CODE), 2);
    ticks(7 * FRAME_LEN);
    key_mask = '0;
    ticks(3 * FRAME_LEN - 1);
    checkOutput("release_early", 32'(KEY_EVENT), 1);
    tick();
    checkOutput("release_event", 32'(KEY_EVENT), 0);
    checkOutput("release_code", 32'(KEY_CODE), 0);
    ticks(2 * FRAME_LEN);

    $display("[TB] bouncing r1c0");
    for (int f = 0; f < 6; f++) begin
      applyStimulus((f % 2 == 0) ? key_at(1, 0) : '0, 1);
    end
    checkOutput("bounce_code", 32'(KEY_CODE), 0);
    applyStimulus('0, 3);

    $display("[TB] two keys r1c0 + r2c3");
    applyStimulus(key_at(1, 0) | key_at(2, 3), 4);
    checkOutput("two_code", 32'(KEY_CODE), 5);
    applyStimulus(key_at(2, 3), 3);
    checkOutput("two_idle", 32'(KEY_CODE), 0);
    applyStimulus(key_at(2, 3), 3);
    checkOutput("two_second", 32'(KEY_CODE), 12);
    checkOutput("two_second_ev", 32'(KEY_EVENT), 1);
    applyStimulus('0, 4);

    $display("[TB] reset while pressed");
    applyStimulus(key_at(0, 1), 4);
    checkOutput("mid_code", 32'(KEY_CODE), 2);
    #2;
    do_reset(3);
    ticks(3 * FRAME_LEN - 1);
    checkOutput("repress_early", 32'(KEY_EVENT), 0);
    tick();
    checkOutput("repress_event", 32'(KEY_EVENT), 1);
    checkOutput("repress_code", 32'(KEY_CODE), 2);
    applyStimulus('0, 4);

    $display("[TB] long hold of r3c3");
    low_cnt = 0;
    applyStimulus(key_at(3, 3), 3);
    checkOutput("hold_code", 32'(KEY_CODE), 16);
    applyStimulus(key_at(3, 3), 17);
    checkOutput("hold_drops", 32'(low_cnt), REP_DROPS);
    checkOutput("hold_code_end", 32'(KEY_CODE), 16);
    applyStimulus('0, 4);

    $display("[TB] random key patterns");
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0: rnd_mask = '0;
        1: rnd_mask = key_at(0, 0) << $urandom_range(0, NKEYS - 1);
        2: rnd_mask = (key_at(0, 0) << $urandom_range(0, NKEYS - 1)) |
                      (key_at(0, 0) << $urandom_range(0, NKEYS - 1));
        default: rnd_mask = rnd_mask;
      endcase
      applyStimulus(rnd_mask, $urandom_range(1, 6));
    end
    applyStimulus('0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
Matrix keypad front-end that produces the key interface consumed by the CPU core.
- Scans a ROWS x COLS switch matrix and debounces presses.
- Drives KEY_CODE, the 8-bit value read by the IN instructions.
- Drives KEY_EVENT, whose rising edge forces the program counter to the D-register vector.
- Sits between the board pins and the CPU top level, replacing the bench-driven `in` and `key_event`.

Parameters:
ROWS, 4, number of matrix rows
COLS, 4, number of matrix columns; ROWS*COLS must be ≤ 255
SCAN_DIV, 4, clocks each column is driven; must be ≥ 3 to cover synchronizer latency
DEBOUNCE, 3, consecutive identical scan frames needed to accept a press or a release
REPEAT_DELAY, 8, frames held before the first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 4, frames between later auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
CK  input  1  system clock, all state changes on posedge
RST_N  input  1  asynchronous active-low reset
COL_OUT  output  COLS  one-hot active-high column drive
ROW_IN  input  ROWS  row sense; bit r is high when key (r, driven column) is closed; asynchronous to CK
KEY_CODE  output  8  code of the accepted key; 0 when no key is accepted
KEY_EVENT  output  1  high while an accepted key is held

Behaviour:
- Reset (RST_N low, takes effect immediately):
  - COL_OUT = 1 (column 0); KEY_CODE = 0; KEY_EVENT = 0.
  - State = IDLE; all counters and the synchronizer are cleared.
- Synchronization: ROW_IN passes through a 2-flop synchronizer.
- Scan:
  - Column index increments every SCAN_DIV clocks and wraps COLS-1 -> 0.
  - One frame = COLS*SCAN_DIV clocks (16 at defaults).
  - Synchronized rows are sampled on the last clock of each column dwell.
- Key code: key (r, c) = r*COLS + c + 1, range 1..16 at defaults; 0 means no key.
- Frame result = lowest code seen during the frame (lowest-code priority); 0 if none.
- The FSM evaluates only on the clock edge that ends a frame. Outputs are registered and change on that same edge.
- IDLE:
  - result ≠ 0 -> DEBOUNCE; cand = result; cnt = 1.
- DEBOUNCE:
  - result == cand -> cnt+1. When cnt reaches DEBOUNCE: -> PRESSED; KEY_CODE = cand; KEY_EVENT = 1.
  - result == 0 -> IDLE.
  - other nonzero result -> cand = result; cnt = 1.
- PRESSED:
  - result == KEY_CODE -> stay.
  - anything else, including a second key -> RELEASE; cnt = 1.
- RELEASE:
  - result == KEY_CODE -> PRESSED; cnt cleared.
  - otherwise cnt+1. When cnt reaches DEBOUNCE: -> IDLE; KEY_CODE = 0; KEY_EVENT = 0.
- Key rollover: a new key is accepted only after passing back through IDLE; no n-key rollover.
- Invariants:
  - KEY_CODE ≠ 0 if and only if state ∈ {PRESSED, RELEASE}.
  - KEY_CODE is stable whenever KEY_EVENT is high.
- Latency: a key stable from a frame boundary asserts KEY_EVENT on the edge ending frame DEBOUNCE (48 clocks at defaults). Release takes the same latency.
- Reset mid-press: outputs clear at once. A key still held is re-debounced from IDLE like a new press.

Optional Feature:
KEYPAD_REPEAT_EN
- Without the macro: exactly one KEY_EVENT rising edge per accepted press.
- With the macro, while in PRESSED:
  - After REPEAT_DELAY held frames, KEY_EVENT drops for exactly one clock, then returns high, giving a new rising edge to the CPU.
  - Further drops occur every REPEAT_RATE frames.
  - KEY_CODE stays valid during the one-clock drop.
  - The repeat counter clears on entry to PRESSED and on RELEASE.

Decomposition:
- Package keypad_pkg:
  - FSM state encoding: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - KEY_NONE = 8'd0.
  - Code width = 8.
  - Frame-length function COLS*SCAN_DIV.
- Sub-module keypad_scan:
  - Contains the synchronizer, column counter, COL_OUT drive and frame-result priority encoder.
  - Outputs frame_done (1-clock strobe) and frame_code[7:0].
- Top level keypad_encoder holds the FSM, the counters, the optional repeat logic and the output registers.

Test Plan:
1. Reset: RST_N low for 3 clocks, then high, no key -> COL_OUT = 0001 then walks 0010, 0100, 1000 every 4 clocks; KEY_CODE = 0; KEY_EVENT = 0 for 200 clocks.
2. Clean press: key r0c1 closed at a frame boundary for 10 frames, then opened -> KEY_EVENT rises at clock 48 with KEY_CODE = 2; both return to 0 exactly 3 frames after the opening.
3. Bounce: r1c0 alternates closed/open each frame for 6 frames -> KEY_EVENT never rises; KEY_CODE stays 0.
4. Two keys: r1c0 and r2c3 held together -> KEY_CODE = 5. Then drop r1c0 -> RELEASE, then IDLE, then code 12 is accepted 3 frames after IDLE is re-entered.
5. Reset mid-press: assert RST_N low while KEY_CODE = 2 -> outputs 0 within the same clock. Deassert with the key still held -> KEY_EVENT rises again after 3 full frames.
6. Repeat (KEYPAD_REPEAT_EN defined): hold r3c3 -> KEY_CODE = 16. KEY_EVENT is low for 1 clock at 8 frames after acceptance, then every 4 frames; KEY_CODE stays 16 throughout.
